// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, word-length constants and timing default
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam logic [3:0] NBITS_6 = 4'd6;
    localparam logic [3:0] NBITS_7 = 4'd7;
    localparam logic [3:0] NBITS_8 = 4'd8;
    localparam int TICKS_PER_BIT = 4;
    // Anything other than 6 or 7 falls back to a full byte.
    function automatic logic [3:0] eff_nbits(input logic [3:0] n);
        return (n == NBITS_6 || n == NBITS_7) ? n : NBITS_8;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: request, timing strobe and serial-line signals of the transmitter
interface uart_tx_if;
    logic       TxEn;
    logic       TxStart;
    logic [7:0] TxData;
    logic [3:0] NBits;
    logic       Tick;
    logic       Tx;
    logic       TxBusy;
    logic       TxDone;
    modport master(output TxEn, TxStart, TxData, NBits, Tick, input Tx, TxBusy, TxDone);
    modport slave(input TxEn, TxStart, TxData, NBits, Tick, output Tx, TxBusy, TxDone);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts oversampling ticks and flags the tick that ends a bit
module uart_bit_timer #(
    parameter int TICKS_PER_BIT = uart_pkg::TICKS_PER_BIT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clear,
    input  logic tick,
    output logic bit_end
);
    localparam logic [3:0] LAST = 4'(TICKS_PER_BIT - 1);
    logic [3:0] count;
    assign bit_end = tick && !clear && count == LAST;
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n)
            count <= '0;
        else if (clear || bit_end)
            count <= '0;
        else if (tick)
            count <= count + 4'd1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises a 6/7/8-bit word as start, LSB-first data and stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = uart_pkg::TICKS_PER_BIT,
    parameter int STOP_BITS     = 1
) (
    input logic      Clk,
    input logic      Rst_n,
    uart_tx_if.slave bus
);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    uart_state_e state;
    logic [7:0]  shift;
    logic [3:0]  nbits;
    logic [3:0]  bit_idx;
    logic        bit_end;

    // Held clear while idle so a Tick coinciding with acceptance is not counted.
    uart_bit_timer #(.TICKS_PER_BIT(TICKS_PER_BIT)) timer (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .clear   (state == IDLE),
        .tick    (bus.Tick),
        .bit_end (bit_end)
    );

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            nbits      <= '0;
            bit_idx    <= '0;
            bus.Tx     <= 1'b1;
            bus.TxBusy <= 1'b0;
            bus.TxDone <= 1'b0;
        end else begin
            bus.TxDone <= 1'b0;
            case (state)
                IDLE: if (bus.TxStart && bus.TxEn) begin
                    state      <= START;
                    shift      <= bus.TxData;
                    nbits      <= eff_nbits(bus.NBits);
                    bit_idx    <= '0;
                    bus.Tx     <= 1'b0;
                    bus.TxBusy <= 1'b1;
                end
                START: if (bit_end) begin
                    state  <= DATA;
                    bus.Tx <= shift[0];
                end
                DATA: if (bit_end) begin
                    shift <= shift >> 1;
                    if (bit_idx == nbits - 4'd1) begin
                        state   <= STOP;
                        bit_idx <= '0;
                        bus.Tx  <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        bus.Tx  <= shift[1];
                    end
                end
                STOP: if (bit_end) begin
                    if (bit_idx == LAST_STOP) begin
                        state      <= IDLE;
                        bus.TxBusy <= 1'b0;
                        bus.TxDone <= 1'b1;
                    end else
                        bit_idx <= bit_idx + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit side paired with the team's UART receiver. It accepts a parallel byte plus a run-time word length of 6, 7 or 8 bits and serialises it onto `Tx` as a frame: start bit, data bits LSB first, then stop bit(s). Bit timing comes from the shared oversampling `Tick` strobe, at `TICKS_PER_BIT` ticks per bit, so frames line up with the receiver's sampling.

## Interface
- `TICKS_PER_BIT`, default 4: Tick pulses per serial bit; legal range 2–16.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `Clk`  in  1  system clock.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `TxEn`  in  1  transmitter enable; gates acceptance of new frames only.
- `TxStart`  in  1  request strobe; sampled every Clk.
- `TxData`  in  8  payload; used bits are `[NBits-1:0]`.
- `NBits`  in  4  word length; 6, 7 or 8; any other value behaves as 8.
- `Tick`  in  1  one-Clk-wide baud×TICKS_PER_BIT strobe, synchronous to Clk.
- `Tx`  out  1  serial line; registered; idles high.
- `TxBusy`  out  1  high while a frame is in progress.
- `TxDone`  out  1  one-Clk pulse when a frame completes.

## Operation
- Reset values: `Tx`=1, `TxBusy`=0, `TxDone`=0; state IDLE; all counters 0. Reset is asynchronous and forces the line high immediately, even mid-frame.
- States and transitions: IDLE → START → DATA → STOP → IDLE.
- IDLE:
  - `Tx`=1.
  - If `TxStart & TxEn`: latch `TxData` into an 8-bit shift register, latch the effective word length (6/7/8) into a bit-count register, clear the tick and bit counters, go to START.
- START:
  - `Tx`=0.
  - Tick counter increments on each `Tick`.
  - On the Tick where counter = TICKS_PER_BIT-1: clear counter, go to DATA.
- DATA:
  - `Tx`=shift[0].
  - At each bit end (same Tick rule as START): shift right by one and increment the bit index.
  - After the latched-word-length-th bit ends: go to STOP.
  - Bits above the word length are never transmitted.
- STOP:
  - `Tx`=1 for STOP_BITS×TICKS_PER_BIT ticks.
  - At the final tick: go to IDLE and pulse `TxDone`.
- `TxBusy` = (state ≠ IDLE).
- Boundary behaviour:
  - `TxStart` while busy: ignored; no queueing.
  - `TxData` and `NBits` changing mid-frame: no effect, because both are latched at acceptance.
  - `TxEn` deasserted mid-frame: the current frame completes normally; no new acceptance.
  - `TxStart` and `Tick` in the same IDLE cycle: frame accepted; that Tick is not counted.
  - `Tick` absent: the state holds indefinitely; no timeout.
  - Tick counter and bit counter are sized for the maximum parameter values. No wrap-around is possible within a frame.

## Timing
- Acceptance edge to `Tx` low: 1 Clk. The first start-bit period is therefore between TICKS_PER_BIT-1 and TICKS_PER_BIT tick periods, depending on Tick phase.
- Every later bit lasts exactly TICKS_PER_BIT Tick pulses. `Tx` changes only on the Clk edge following a bit-ending Tick.
- Frame length in Ticks ≈ (1 + NBits + STOP_BITS)×TICKS_PER_BIT. Example: 8N1 at default parameters = 40 Ticks.
- Completion cycle (the cycle after the final stop Tick): `TxDone`=1, `TxBusy`=0, `Tx`=1.
- A `TxStart` in the completion cycle is accepted, giving back-to-back frames with only one extra Clk of idle.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - word-length constants NBITS_6=4'd6, NBITS_7=4'd7, NBITS_8=4'd8;
  - the default TICKS_PER_BIT=4, which is common with the receiver.
- One sub-module is natural: `uart_bit_timer`.
  - Counts Ticks and asserts `bit_end` on the Tick where count = TICKS_PER_BIT-1.
  - Cleared by the FSM on acceptance.
  - Reusable by the receiver.
- The FSM, shift register and bit counter live in `uart_tx`.

## Test plan
- Reset held, then released. Expect `Tx`=1, `TxBusy`=0, `TxDone`=0. Pulse `Rst_n` low mid-frame: `Tx` returns to 1 asynchronously, and `TxBusy` drops.
- `TxData`=8'hA5, `NBits`=8, Tick every 10 Clk. Expect on `Tx`: 0, 1,0,1,0,0,1,0,1, then 1. Each bit lasts 4 Ticks; `TxDone` pulses once; frame spans 40 Ticks.
- `TxData`=8'hFF, `NBits`=6, then 7. Exactly 6 (then 7) ones follow the start bit, and the stop bit begins immediately after. An illegal `NBits`=4'd3 produces an 8-bit frame.
- `TxStart` pulsed mid-frame with new data 8'h3C. It is ignored: the frame still carries the original byte, with a single `TxDone`.
- `TxStart` asserted in the `TxDone` cycle with 8'h0F then 8'hF0. Two contiguous frames, both correct. `TxEn`=0 at request time blocks acceptance.
- Parameter sweep with TICKS_PER_BIT=16 and STOP_BITS=2. Bits last 16 Ticks, and the stop period lasts 32 Ticks high. Loopback into the receiver recovers 8'h5A.
